// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes a valid/ready bitstream into the
// ccff chain, optionally reads it back, and gates IO isolation on the result.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic [DATA_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  mismatch_idx
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE, S_ERROR} state_t;

    state_t            state_q, state_d;
    logic              verify_q, verify_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, base_cnt, fetch_left, mis_idx_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [BW-1:0]     buf_cnt_q, buf_cnt_d, usable;
    logic              head_d, en_d, flag_q, flag_d;
    logic              streaming, pass_end, cont, take, mism_now;

    always_comb begin
        pass_end  = (cnt_q == LEN);
        streaming = (state_q == S_LOAD) || (state_q == S_VERIFY);
        // A LOAD pass that hands over to VERIFY keeps streaming through its last
        // shift cycle so the second pass starts without a gap.
        cont       = streaming && !(pass_end && !((state_q == S_LOAD) && verify_q));
        base_cnt   = pass_end ? '0 : cnt_q;
        fetch_left = LEN - base_cnt - CNT_W'(buf_cnt_q);
        usable     = (32'(fetch_left) >= 32'(DATA_W)) ? BW'(DATA_W) : BW'(fetch_left);
        bs_ready   = cont && (buf_cnt_q <= BW'(1)) && (fetch_left != '0);
        take       = bs_valid && bs_ready;
        mism_now   = (state_q == S_VERIFY) && chain_clk_en && (ccff_head != ccff_tail);

        state_d   = state_q;
        verify_d  = verify_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        head_d    = ccff_head;
        en_d      = 1'b0;
        flag_d    = flag_q | mism_now;
        mis_idx_d = (mism_now && !flag_q) ? (cnt_q - CNT_W'(1)) : mismatch_idx;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d   = S_LOAD;
                    verify_d  = verify_en;
                    cnt_d     = '0;
                    buf_d     = '0;
                    buf_cnt_d = '0;
                    flag_d    = 1'b0;
                    mis_idx_d = '0;
                end
            end
            S_LOAD, S_VERIFY: begin
                if (cont) begin
                    cnt_d = base_cnt;
                    if (buf_cnt_q != '0) begin
                        head_d    = buf_q[0];
                        en_d      = 1'b1;
                        cnt_d     = base_cnt + CNT_W'(1);
                        buf_d     = buf_q >> 1;
                        buf_cnt_d = buf_cnt_q - BW'(1);
                        if (take) begin
                            buf_d     = bs_data;
                            buf_cnt_d = usable;
                        end
                    end else if (take) begin
                        // A fresh word bypasses the buffer so its first bit shifts next cycle.
                        head_d    = bs_data[0];
                        en_d      = 1'b1;
                        cnt_d     = base_cnt + CNT_W'(1);
                        buf_d     = bs_data >> 1;
                        buf_cnt_d = usable - BW'(1);
                    end
                end
                if (pass_end) begin
                    if (state_q == S_LOAD) begin
                        state_d = verify_q ? S_VERIFY : S_DONE;
                    end else begin
                        state_d = (flag_q || mism_now) ? S_ERROR : S_DONE;
                    end
                    if (!cont) begin
                        cnt_d     = '0;
                        buf_d     = '0;
                        buf_cnt_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q      <= S_IDLE;
            verify_q     <= 1'b0;
            cnt_q        <= '0;
            buf_q        <= '0;
            buf_cnt_q    <= '0;
            ccff_head    <= 1'b0;
            chain_clk_en <= 1'b0;
            flag_q       <= 1'b0;
            mismatch_idx <= '0;
        end else begin
            state_q      <= state_d;
            verify_q     <= verify_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            buf_cnt_q    <= buf_cnt_d;
            ccff_head    <= head_d;
            chain_clk_en <= en_d;
            flag_q       <= flag_d;
            mismatch_idx <= mis_idx_d;
        end
    end

    assign busy      = streaming;
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign IO_ISOL_N = (state_q == S_DONE);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: 10-bit chain model on ccff_tail, bitstream
// reference built from the source words, one task per scenario.
module tb_ccff_chain_loader;

    localparam int CL = 10;
    localparam int DW = 4;
    localparam int CW = $clog2(CL + 1);

    logic          prog_clk = 1'b0;
    logic          prog_reset_n = 1'b0;
    logic          start = 1'b0;
    logic          verify_en = 1'b0;
    logic [DW-1:0] bs_data = '0;
    logic          bs_valid = 1'b0;
    logic          bs_ready, ccff_head, ccff_tail, chain_clk_en;
    logic          IO_ISOL_N, busy, done, error;
    logic [CW-1:0] mismatch_idx;

    int checks = 0;
    int errors = 0;

    // Chain model; the cell receiving stream bit fault_pos captures 0 instead.
    logic [CL-1:0] chain = '0;
    int            push_total = 0;
    int            fault_pos = -1;
    assign ccff_tail = chain[CL-1];
    always @(posedge prog_clk) begin
        if (chain_clk_en) begin
            chain      <= {chain[CL-2:0], (push_total == fault_pos) ? 1'b0 : ccff_head};
            push_total <= push_total + 1;
        end
    end

    ccff_chain_loader #(.CHAIN_LEN(CL), .DATA_W(DW)) dut (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
        .verify_en(verify_en), .bs_data(bs_data), .bs_valid(bs_valid),
        .bs_ready(bs_ready), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
        .chain_clk_en(chain_clk_en), .IO_ISOL_N(IO_ISOL_N), .busy(busy),
        .done(done), .error(error), .mismatch_idx(mismatch_idx)
    );

    always #5 prog_clk = ~prog_clk;

    logic [DW-1:0] words [3];
    bit            head_q[$];
    bit            exp_q[$];
    int            sh_cnt, gap_cnt, first_sh, last_sh, term_cycle;
    bit            held_ok, ready_late, io_c1, done_c1, ready_c1, en_term;

    function automatic void build_exp(input int passes);
        exp_q.delete();
        for (int p = 0; p < passes; p++)
            for (int k = 0; k < CL; k++)
                exp_q.push_back(words[k / DW][k % DW]);
    endfunction

    function automatic int seq_bad();
        if (head_q.size() != exp_q.size()) return -2;
        for (int i = 0; i < head_q.size(); i++)
            if (head_q[i] != exp_q[i]) return i;
        return -1;
    endfunction

    function automatic logic [CL-1:0] exp_chain();
        logic [CL-1:0] v;
        for (int k = 0; k < CL; k++) v[CL-1-k] = words[k / DW][k % DW];
        return v;
    endfunction

    function automatic void rand_words();
        for (int i = 0; i < 3; i++) words[i] = DW'($urandom);
    endfunction

    task automatic run_op(input bit ver, input bit fault, input int stall_word, input int stall_len,
                          input int extra_start, input int abort_after);
        int c, widx, stall, passes;
        bit fin, prev_head;
        passes = ver ? 2 : 1;
        sh_cnt = 0; gap_cnt = 0; first_sh = -1; last_sh = -1; term_cycle = -1;
        held_ok = 1; ready_late = 0; en_term = 0; prev_head = 0;
        head_q.delete();
        widx = 0; stall = stall_len; fin = 0; c = 0;
        @(negedge prog_clk);
        fault_pos = fault ? push_total + 6 : -1;
        start = 1; verify_en = ver; bs_valid = 0;
        while (!fin && c < 200) begin
            @(negedge prog_clk);
            c++;
            start = (c == extra_start);
            verify_en = 1'($urandom_range(0, 1));
            if (c == 1) begin io_c1 = IO_ISOL_N; done_c1 = done; ready_c1 = bs_ready; end
            if (chain_clk_en) begin
                if (first_sh < 0) first_sh = c;
                last_sh = c; sh_cnt++;
                head_q.push_back(ccff_head);
                prev_head = ccff_head;
            end else if (first_sh >= 0 && busy) begin
                gap_cnt++;
                if (ccff_head !== prev_head) held_ok = 0;
            end
            if (done || error) begin term_cycle = c; en_term = chain_clk_en; fin = 1; end
            if (abort_after >= 0 && sh_cnt == abort_after) fin = 1;
            if (widx >= 3 * passes && bs_ready) ready_late = 1;
            if (fin) begin
                bs_valid = 0;
            end else if (bs_ready && widx == stall_word && stall > 0) begin
                bs_valid = 0; stall--;
            end else begin
                bs_valid = 1; bs_data = words[widx % 3];
                if (bs_ready) widx++;
            end
        end
        start = 0;
        checks++;
        if (!fin) begin errors++; $display("FAIL op_timeout got cycles %0d exp termination", c); end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bs_ready, ccff_head, chain_clk_en, IO_ISOL_N, busy, done, error, mismatch_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0",
                     {bs_ready, ccff_head, chain_clk_en, IO_ISOL_N, busy, done, error, mismatch_idx});
        end
        @(negedge prog_clk); prog_reset_n = 1;
    endtask

    task automatic test_basic();
        words[0] = 4'h5; words[1] = 4'hA; words[2] = 4'h3;
        build_exp(1);
        run_op(0, 0, -1, 0, -1, -1);
        checks++; if (ready_c1 !== 1'b1) begin errors++; $display("FAIL basic_ready_c1 got %0d exp 1", ready_c1); end
        checks++; if (sh_cnt != CL) begin errors++; $display("FAIL basic_shifts got %0d exp %0d", sh_cnt, CL); end
        checks++; if (seq_bad() != -1) begin errors++; $display("FAIL basic_head_seq got bad idx %0d exp -1", seq_bad()); end
        checks++; if (gap_cnt != 0 || last_sh - first_sh + 1 != CL) begin
            errors++; $display("FAIL basic_contiguous got gap %0d span %0d exp 0 %0d", gap_cnt, last_sh - first_sh + 1, CL); end
        checks++; if (ready_late) begin errors++; $display("FAIL basic_ready_after_last got 1 exp 0"); end
        checks++; if (term_cycle != CL + 2 || en_term) begin
            errors++; $display("FAIL basic_latency got %0d en %0d exp %0d en 0", term_cycle, en_term, CL + 2); end
        checks++; if ({done, IO_ISOL_N, error} !== 3'b110) begin
            errors++; $display("FAIL basic_flags got %b exp 110", {done, IO_ISOL_N, error}); end
        checks++; if (chain !== exp_chain()) begin errors++; $display("FAIL basic_chain got %b exp %b", chain, exp_chain()); end
    endtask

    task automatic test_stall();
        words[0] = 4'h5; words[1] = 4'hA; words[2] = 4'h3;
        build_exp(1);
        // Four ready cycles without valid; the first overlaps the last buffered bit.
        run_op(0, 0, 1, 4, -1, -1);
        checks++; if (sh_cnt != CL) begin errors++; $display("FAIL stall_shifts got %0d exp %0d", sh_cnt, CL); end
        checks++; if (seq_bad() != -1) begin errors++; $display("FAIL stall_head_seq got bad idx %0d exp -1", seq_bad()); end
        checks++; if (gap_cnt != 3 || !held_ok) begin
            errors++; $display("FAIL stall_gap got %0d held %0d exp 3 held 1", gap_cnt, held_ok); end
        checks++; if (term_cycle != CL + 5) begin errors++; $display("FAIL stall_latency got %0d exp %0d", term_cycle, CL + 5); end
        checks++; if (chain !== exp_chain()) begin errors++; $display("FAIL stall_chain got %b exp %b", chain, exp_chain()); end
    endtask

    task automatic test_verify_pass();
        rand_words();
        build_exp(2);
        run_op(1, 0, -1, 0, -1, -1);
        checks++; if (sh_cnt != 2 * CL || gap_cnt != 0) begin
            errors++; $display("FAIL vpass_shifts got %0d gap %0d exp %0d gap 0", sh_cnt, gap_cnt, 2 * CL); end
        checks++; if (seq_bad() != -1) begin errors++; $display("FAIL vpass_head_seq got bad idx %0d exp -1", seq_bad()); end
        checks++; if (term_cycle != 2 * CL + 2) begin errors++; $display("FAIL vpass_latency got %0d exp %0d", term_cycle, 2 * CL + 2); end
        checks++; if ({done, IO_ISOL_N, error} !== 3'b110 || mismatch_idx !== '0) begin
            errors++; $display("FAIL vpass_flags got %b idx %0d exp 110 idx 0", {done, IO_ISOL_N, error}, mismatch_idx); end
    endtask

    task automatic test_verify_fail();
        int exp_idx;
        rand_words();
        words[1][2] = 1'b1;
        exp_idx = -1;
        for (int k = 0; k < CL; k++)
            if (exp_idx < 0 && k == 6 && words[k / DW][k % DW]) exp_idx = k;
        run_op(1, 1, -1, 0, -1, -1);
        checks++; if (sh_cnt != 2 * CL) begin errors++; $display("FAIL vfail_shifts got %0d exp %0d", sh_cnt, 2 * CL); end
        checks++; if ({done, IO_ISOL_N, error} !== 3'b001) begin
            errors++; $display("FAIL vfail_flags got %b exp 001", {done, IO_ISOL_N, error}); end
        checks++; if (int'(mismatch_idx) != exp_idx) begin
            errors++; $display("FAIL vfail_idx got %0d exp %0d", mismatch_idx, exp_idx); end
        checks++; if (bs_ready !== 1'b0) begin errors++; $display("FAIL vfail_ready got %0d exp 0", bs_ready); end
    endtask

    task automatic test_reset_mid();
        rand_words();
        run_op(0, 0, -1, 0, -1, -1);
        #2 prog_reset_n = 0;
        #1;
        checks++; if ({IO_ISOL_N, done} !== 2'b00) begin
            errors++; $display("FAIL reset_async_done got %b exp 00", {IO_ISOL_N, done}); end
        @(negedge prog_clk); prog_reset_n = 1;
        run_op(0, 0, -1, 0, -1, 5);
        #2 prog_reset_n = 0;
        #1;
        checks++;
        if ({bs_ready, ccff_head, chain_clk_en, IO_ISOL_N, busy, done, error, mismatch_idx} !== '0 || sh_cnt != 5) begin
            errors++;
            $display("FAIL reset_mid_outputs got %b shifts %0d exp 0 shifts 5",
                     {bs_ready, ccff_head, chain_clk_en, IO_ISOL_N, busy, done, error, mismatch_idx}, sh_cnt);
        end
        @(negedge prog_clk); prog_reset_n = 1;
        rand_words();
        build_exp(1);
        run_op(0, 0, -1, 0, -1, -1);
        checks++; if (sh_cnt != CL || seq_bad() != -1 || done !== 1'b1) begin
            errors++; $display("FAIL reset_reload got shifts %0d bad %0d done %0d exp %0d -1 1", sh_cnt, seq_bad(), done, CL); end
    endtask

    task automatic test_start_handling();
        rand_words();
        build_exp(1);
        run_op(0, 0, -1, 0, 5, -1);
        checks++; if (sh_cnt != CL || term_cycle != CL + 2 || seq_bad() != -1) begin
            errors++; $display("FAIL start_in_load got shifts %0d term %0d bad %0d exp %0d %0d -1",
                               sh_cnt, term_cycle, seq_bad(), CL, CL + 2); end
        rand_words();
        build_exp(1);
        run_op(0, 0, -1, 0, -1, -1);
        checks++; if ({io_c1, done_c1} !== 2'b00) begin
            errors++; $display("FAIL start_in_done_c1 got %b exp 00", {io_c1, done_c1}); end
        checks++; if (sh_cnt != CL || seq_bad() != -1 || {done, IO_ISOL_N} !== 2'b11) begin
            errors++; $display("FAIL start_in_done_reload got shifts %0d bad %0d flags %b exp %0d -1 11",
                               sh_cnt, seq_bad(), {done, IO_ISOL_N}, CL); end
    endtask

    task automatic test_random();
        bit ver;
        for (int it = 0; it < 4; it++) begin
            rand_words();
            ver = 1'($urandom_range(0, 1));
            build_exp(ver ? 2 : 1);
            run_op(ver, 0, $urandom_range(0, 2), $urandom_range(0, 3), -1, -1);
            checks++;
            if (sh_cnt != (ver ? 2 : 1) * CL || seq_bad() != -1 || {done, error} !== 2'b10 ||
                term_cycle != last_sh + 1 || !held_ok) begin
                errors++;
                $display("FAIL random_%0d got shifts %0d bad %0d flags %b term %0d last %0d held %0d",
                         it, sh_cnt, seq_bad(), {done, error}, term_cycle, last_sh, held_ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_verify_pass();
        test_verify_fail();
        test_reset_mid();
        test_start_handling();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
